// File: rtl/io_ctrl_pkg.sv
// Shared constants for the IO access controller: FSM state encoding and
// IO register-select codes.
package io_ctrl_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // IO register select values driven on io_dir_o.
  localparam logic [1:0] IO_CTL = 2'd0;
  localparam logic [1:0] IO_PA  = 2'd1;
  localparam logic [1:0] IO_PB  = 2'd2;
  localparam logic [1:0] IO_PC  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: a lone requester wins,
// and on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the winner from the two requests and the previous owner.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/io_access_ctrl.sv
// Sequences accesses from two requesters onto the 8-bit IO interface:
// round-robin arbitration, one setup cycle, a strobe of STROBE_CYC cycles,
// read-data capture at the end of the strobe, and a one-cycle acknowledge.
// Every output comes straight from a flop.
module io_access_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] io_dir_o,
  output logic [DATA_W-1:0] io_data_o,
  output logic              io_wr_o,
  output logic              io_rd_o,
  input  logic [DATA_W-1:0] io_data_i,
  output logic              busy_o,
  output logic              grant_o
);

  state_t state_q, state_d;
  logic   grant_valid, grant_idx;
  logic   last_grant_q;
  logic   owner_q;
  logic   we_q;
  logic   [3:0] cnt_q;

  rr_arb2 u_arb (
    .req0        (req0_i),
    .req1        (req1_i),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state logic: arbitration only happens from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (cnt_q == 4'd0) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; last_grant starts at 1 so requester 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's request on entry to SETUP; held through ACK and beyond.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      grant_o      <= 1'b0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      io_dir_o     <= '0;
      io_data_o    <= '0;
    end else if (state_q == ST_IDLE && grant_valid) begin
      last_grant_q <= grant_idx;
      grant_o      <= grant_idx;
      owner_q      <= grant_idx;
      we_q         <= grant_idx ? we1_i : we0_i;
      io_dir_o     <= grant_idx ? addr1_i : addr0_i;
      io_data_o    <= grant_idx ? wdata1_i : wdata0_i;
    end
  end

  // Strobe-length down-counter, loaded as the strobe begins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= 4'(STROBE_CYC - 1);
    end else if (state_q == ST_STROBE && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Capture read data on the edge that ends the last strobe cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata0_o <= '0;
      rdata1_o <= '0;
    end else if (state_q == ST_STROBE && cnt_q == 4'd0 && !we_q) begin
      if (owner_q) rdata1_o <= io_data_i;
      else         rdata0_o <= io_data_i;
    end
  end

  // Registered strobes, acks and busy, decoded from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      io_wr_o <= 1'b0;
      io_rd_o <= 1'b0;
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      io_wr_o <= (state_d == ST_STROBE) &&  we_q;
      io_rd_o <= (state_d == ST_STROBE) && !we_q;
      ack0_o  <= (state_d == ST_ACK) && !owner_q;
      ack1_o  <= (state_d == ST_ACK) &&  owner_q;
      busy_o  <= (state_d != ST_IDLE);
    end
  end

endmodule
